attention_scheduler: RTL and testbench

Sequencing controller for one `PE` backend. On a start pulse it walks the attention problem row by row:
- fetches one Q vector;
- streams all NUM_KV K/V vector pairs against it;
- tracks the normalised output row through to OSRAM.

It sits between the Q/KV SRAM fetch front-ends and the OSRAM write port. It drives fetch addresses, marks the last key of each row, and generates the output row address.

---
 rtl/attention_scheduler.sv | 102 ++++++++++
 tb/tb_attention_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/attention_scheduler.sv
// attention_scheduler: row-by-row Q fetch / KV stream / output-row sequencer for one PE backend.
// Define AURA_SCHED_OVERLAP_EN to let the next row's Q fetch start while up to one earlier output row is still pending.
module attention_scheduler #(
    parameter int NUM_Q  = 64,
    parameter int NUM_KV = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              q_fetch_vld,
    input  logic              q_fetch_rdy,
    output logic [ADDR_W-1:0] q_fetch_addr,
    output logic              kv_fetch_vld,
    input  logic              kv_fetch_rdy,
    output logic [ADDR_W-1:0] kv_fetch_addr,
    output logic              kv_last,
    input  logic              o_vld,
    input  logic              o_rdy,
    output logic [ADDR_W-1:0] o_addr
);
    typedef enum logic [2:0] {IDLE, FETCH_Q, STREAM_KV, WAIT_O, DONE} state_t;
`ifdef AURA_SCHED_OVERLAP_EN
    localparam logic [1:0] CAP = 2'd2;
`else
    localparam logic [1:0] CAP = 2'd1;
`endif
    localparam logic [ADDR_W-1:0] Q_LAST  = ADDR_W'(NUM_Q - 1);
    localparam logic [ADDR_W-1:0] KV_LAST = ADDR_W'(NUM_KV - 1);
    state_t            state, state_n;
    logic [ADDR_W-1:0] q_row, q_row_n, kv_idx, kv_idx_n, o_row, o_row_n;
    logic [1:0]        pend, pend_n;
    logic              q_hs, kv_hs, kv_end, o_hs, more, adv;
    always_comb begin
        q_hs     = q_fetch_vld & q_fetch_rdy;
        kv_hs    = kv_fetch_vld & kv_fetch_rdy;
        kv_end   = kv_hs & kv_last;
        // output handshakes with nothing pending are protocol errors and dropped
        o_hs     = o_vld & o_rdy & (state != IDLE) & (pend != 2'd0);
        pend_n   = pend + {1'b0, kv_end} - {1'b0, o_hs};
        o_row_n  = o_row + ADDR_W'(o_hs);
        more     = q_row != Q_LAST;
        adv      = more && (pend_n < CAP);
        kv_idx_n = kv_hs ? (kv_last ? '0 : kv_idx + ADDR_W'(1)) : kv_idx;
        q_row_n  = q_row;
        state_n  = state;
        case (state)
            IDLE: if (start) begin
                state_n  = FETCH_Q;
                q_row_n  = '0;
                kv_idx_n = '0;
                o_row_n  = '0;
                pend_n   = '0;
            end
            FETCH_Q:   state_n = q_hs ? STREAM_KV : FETCH_Q;
            STREAM_KV: if (kv_end) begin
                state_n = adv ? FETCH_Q : WAIT_O;
                q_row_n = adv ? q_row + ADDR_W'(1) : q_row;
            end
            WAIT_O: if (adv) begin
                state_n = FETCH_Q;
                q_row_n = q_row + ADDR_W'(1);
            end else if (!more && pend_n == 2'd0) begin
                state_n = DONE;
            end
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            q_row         <= '0;
            kv_idx        <= '0;
            o_row         <= '0;
            pend          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            q_fetch_vld   <= 1'b0;
            q_fetch_addr  <= '0;
            kv_fetch_vld  <= 1'b0;
            kv_fetch_addr <= '0;
            kv_last       <= 1'b0;
            o_addr        <= '0;
        end else begin
            state         <= state_n;
            q_row         <= q_row_n;
            kv_idx        <= kv_idx_n;
            o_row         <= o_row_n;
            pend          <= pend_n;
            busy          <= state_n != IDLE;
            done          <= state_n == DONE;
            q_fetch_vld   <= state_n == FETCH_Q;
            q_fetch_addr  <= q_row_n;
            kv_fetch_vld  <= state_n == STREAM_KV;
            kv_fetch_addr <= kv_idx_n;
            kv_last       <= (state_n == STREAM_KV) && (kv_idx_n == KV_LAST);
            o_addr        <= o_row_n;
        end
    end
endmodule

// File: tb/tb_attention_scheduler.sv
// tb_attention_scheduler: randomized and directed stimulus with a queue scoreboard for attention_scheduler.
module tb_attention_scheduler;
`ifdef AURA_SCHED_OVERLAP_EN
    localparam int NQ = 3, NKV = 2, CAP = 2, ODLY = 20;
`else
    localparam int NQ = 2, NKV = 3, CAP = 1, ODLY = 2;
`endif
    localparam int AW = 4;
    logic clk = 0, rst_n = 0, start = 0;
    logic q_fetch_rdy = 0, kv_fetch_rdy = 0, o_vld = 0, o_rdy = 0;
    logic busy, done, q_fetch_vld, kv_fetch_vld, kv_last;
    logic [AW-1:0] q_fetch_addr, kv_fetch_addr, o_addr, q_prev, kv_prev, hold_addr;
    logic kvl_prev;
    int total = 0, bad = 0, cyc = 0, mode = 0, pend = 0, q_issued = 0, done_cnt = 0;
    int runs_started = 0, runs_seen = 0, exp_runs = 0, a, l, pa;
    int q_exp[$], kv_a[$], kv_l[$], o_exp[$], due[$];
    bit q_stall, kv_stall, qn_chk, qn_exp, dn_exp, bl_exp, ohs;

    attention_scheduler #(.NUM_Q(NQ), .NUM_KV(NKV), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .q_fetch_vld(q_fetch_vld), .q_fetch_rdy(q_fetch_rdy), .q_fetch_addr(q_fetch_addr),
        .kv_fetch_vld(kv_fetch_vld), .kv_fetch_rdy(kv_fetch_rdy), .kv_fetch_addr(kv_fetch_addr),
        .kv_last(kv_last), .o_vld(o_vld), .o_rdy(o_rdy), .o_addr(o_addr));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor and scoreboard: owns the reference model of the run
    always @(negedge clk) begin
        if (!rst_n) begin
            q_exp.delete(); kv_a.delete(); kv_l.delete(); o_exp.delete(); due.delete();
            pend = 0; q_issued = 0; q_stall = 0; kv_stall = 0;
            qn_chk = 0; dn_exp = 0; bl_exp = 0; runs_seen = runs_started;
        end else begin
            if (bl_exp) begin
                chk("busy_low_after_done", busy, 0);
                bl_exp = 0;
            end
            if (dn_exp || done) begin
                chk("done_pulse", done, dn_exp);
                if (dn_exp) begin
                    chk("busy_during_done", busy, 1);
                    bl_exp = 1;
                    done_cnt++;
                end
                dn_exp = 0;
            end
            if (qn_chk) begin
                chk("q_vld_after_last_kv", q_fetch_vld, qn_exp);
                qn_chk = 0;
            end
            if (q_stall) begin
                chk("q_hold_vld", q_fetch_vld, 1);
                chk("q_hold_addr", q_fetch_addr, q_prev);
            end
            if (kv_stall) begin
                chk("kv_hold_vld", kv_fetch_vld, 1);
                chk("kv_hold_addr", kv_fetch_addr, kv_prev);
                chk("kv_hold_last", kv_last, kvl_prev);
            end
            q_stall = q_fetch_vld && !q_fetch_rdy; q_prev = q_fetch_addr;
            kv_stall = kv_fetch_vld && !kv_fetch_rdy; kv_prev = kv_fetch_addr; kvl_prev = kv_last;
            if (runs_started != runs_seen) begin
                runs_seen++;
                q_issued = 0;
                for (int r = 0; r < NQ; r++) begin
                    q_exp.push_back(r);
                    o_exp.push_back(r);
                    for (int k = 0; k < NKV; k++) begin
                        kv_a.push_back(k);
                        kv_l.push_back(int'(k == NKV - 1));
                    end
                end
            end
            ohs = o_vld && o_rdy && pend > 0;
            if (q_fetch_vld && q_fetch_rdy) begin
                if (q_exp.size() == 0) chk("q_extra", int'(q_fetch_addr), -1);
                else begin
                    chk("q_addr", q_fetch_addr, q_exp.pop_front());
                    chk("q_gate_pending", int'(pend < CAP), 1);
                    q_issued++;
                end
            end
            if (kv_fetch_vld && kv_fetch_rdy) begin
                if (kv_a.size() == 0) chk("kv_extra", int'(kv_fetch_addr), -1);
                else begin
                    a = kv_a.pop_front();
                    l = kv_l.pop_front();
                    chk("kv_addr", kv_fetch_addr, a);
                    chk("kv_last", kv_last, l);
                    if (l != 0) begin
                        pa = pend + 1 - int'(ohs);
                        qn_chk = 1;
                        qn_exp = (q_issued < NQ) && (pa < CAP);
                        pend++;
                        due.push_back(cyc + ODLY);
                    end
                end
            end
            if (ohs) begin
                if (o_exp.size() == 0) chk("o_extra", int'(o_addr), -1);
                else chk("o_addr", o_addr, o_exp.pop_front());
                pend--;
                void'(due.pop_front());
                if (o_exp.size() == 0 && q_exp.size() == 0) dn_exp = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (mode == 1) begin
            q_fetch_rdy = 1; kv_fetch_rdy = 1; o_rdy = 1;
            o_vld = due.size() > 0 && cyc >= due[0];
        end else if (mode == 2) begin
            q_fetch_rdy = 1'($urandom);
            kv_fetch_rdy = 1'($urandom);
            o_vld = pend > 0 && 1'($urandom);
            o_rdy = 1'($urandom);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_q_vld"}, q_fetch_vld, 0);
        chk({tag, "_kv_vld"}, kv_fetch_vld, 0);
        chk({tag, "_kv_last"}, kv_last, 0);
        chk({tag, "_q_addr"}, q_fetch_addr, 0);
        chk({tag, "_kv_addr"}, kv_fetch_addr, 0);
        chk({tag, "_o_addr"}, o_addr, 0);
    endtask

    task automatic start_run();
        start = 1;
        runs_started++;
        tick();
        start = 0;
        chk("start_busy", busy, 1);
        chk("start_q_vld", q_fetch_vld, 1);
        chk("start_q_addr", q_fetch_addr, 0);
    endtask

    task automatic wait_done();
        exp_runs++;
        for (int i = 0; i < 2000 && done_cnt < exp_runs; i++) tick();
        chk("done_count", done_cnt, exp_runs);
        tick();
        tick();
    endtask

    initial begin
        tick();
        tick();
        check_idle("reset");
        rst_n = 1;
        tick();
        // nominal run, all ready, output two cycles after each last key
        mode = 1;
        start_run();
        wait_done();
        // random ready stalls
        mode = 2;
        repeat (4) begin
            start_run();
            wait_done();
        end
        // output port back-pressure while a row is pending
        mode = 0; q_fetch_rdy = 1; kv_fetch_rdy = 1; o_vld = 0; o_rdy = 0;
        start_run();
        for (int i = 0; i < 100 && pend == 0; i++) tick();
        chk("reach_wait_o", pend, 1);
        hold_addr = o_addr;
        o_vld = 1;
        repeat (10) begin
            tick();
            chk("o_hold_addr", o_addr, hold_addr);
`ifndef AURA_SCHED_OVERLAP_EN
            chk("no_q_while_o_blocked", q_fetch_vld, 0);
`endif
        end
        o_rdy = 1;
        tick();
        o_vld = 0; o_rdy = 0;
`ifndef AURA_SCHED_OVERLAP_EN
        chk("q_after_o_rdy", q_fetch_vld, 1);
`endif
        mode = 1;
        wait_done();
        // reset in the middle of the KV stream
        mode = 0; q_fetch_rdy = 1; kv_fetch_rdy = 1; o_vld = 0; o_rdy = 0;
        start_run();
        for (int i = 0; i < 50 && !(kv_fetch_vld && kv_fetch_addr == 1); i++) tick();
        chk("reach_kv1", kv_fetch_addr, 1);
        #2 rst_n = 0;
        #1 check_idle("mid_reset");
        tick();
        tick();
        rst_n = 1;
        tick();
        mode = 1;
        start_run();
        wait_done();
        // start while busy and a spurious output handshake with nothing pending
        mode = 0; q_fetch_rdy = 0; kv_fetch_rdy = 1; o_vld = 0; o_rdy = 0;
        start_run();
        start = 1; o_vld = 1; o_rdy = 1;
        tick();
        start = 0; o_vld = 0; o_rdy = 0;
        chk("spurious_o_addr", o_addr, 0);
        chk("spurious_q_vld", q_fetch_vld, 1);
        chk("spurious_q_addr", q_fetch_addr, 0);
        mode = 1;
        wait_done();
        mode = 0; o_vld = 0;
        repeat (5) tick();
        chk("final_idle", busy, 0);
        chk("final_done_count", done_cnt, exp_runs);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
